// File: rtl/display_pkg.sv
// Shared constants for the output display: active-low 7-segment patterns,
// digit count and the conversion state encoding.
package display_pkg;

    localparam int NUM_DIGITS = 3;

    // Active-low patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } conv_state_t;

    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to three BCD digits,
// one bit per clock, result held in bcd until the next conversion commits.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        busy,
    output logic [11:0] bcd
);

    conv_state_t state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [11:0] scratch_q, scratch_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic        busy_q, busy_d;
    logic [11:0] bcd_q, bcd_d;
    logic [11:0] adj;

    // Add-3 correction on every nibble that would overflow past 9 after the shift
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adjust
        assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5)
                              ? scratch_q[gi*4 +: 4] + 4'd3
                              : scratch_q[gi*4 +: 4];
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        bitcnt_d  = bitcnt_q;
        busy_d    = busy_q;
        bcd_d     = bcd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d   = bin;
                    scratch_d = 12'h000;
                    bitcnt_d  = 3'd0;
                    busy_d    = 1'b1;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, shift_d} = {adj, shift_q} << 1;
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                bcd_d   = scratch_q;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= 8'h00;
            scratch_q <= 12'h000;
            bitcnt_q  <= 3'd0;
            busy_q    <= 1'b0;
            bcd_q     <= 12'h000;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            bitcnt_q  <= bitcnt_d;
            busy_q    <= busy_d;
            bcd_q     <= bcd_d;
        end
    end

    assign busy = busy_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/output_display.sv
// Shows the CPU output register in decimal on a multiplexed 3-digit,
// active-low 7-segment display; reconverts whenever the value changes.
module output_display
    import display_pkg::*;
#(
    parameter int REFRESH_DIV   = 4000,
    parameter int BLANK_LEADING = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  value,
    output logic [6:0]  seg,
    output logic [2:0]  an,
    output logic [11:0] bcd,
    output logic        busy
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [7:0]    last_value_q, last_value_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [6:0]    seg_q, seg_d;
    logic [2:0]    an_q, an_d;
    logic          conv_busy;
    logic [11:0]   conv_bcd;
    logic          accept;
    logic          wrap;
    logic [NUM_DIGITS-1:0] blank;
    logic [6:0]    digit_seg [NUM_DIGITS];

    // Busy is low exactly when the converter sits in IDLE, so a change seen
    // while busy stays pending until the converter is free again.
    assign accept = (value != last_value_q) && !conv_busy;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .bin   (value),
        .busy  (conv_busy),
        .bcd   (conv_bcd)
    );

    assign blank[0] = 1'b0;
    assign blank[1] = (BLANK_LEADING != 0) && (conv_bcd[11:8] == 4'd0)
                      && (conv_bcd[7:4] == 4'd0);
    assign blank[2] = (BLANK_LEADING != 0) && (conv_bcd[11:8] == 4'd0);

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_seg[gi] = blank[gi] ? SEG_OFF : seg_decode(conv_bcd[gi*4 +: 4]);
    end

    assign wrap = (cnt_q == CNT_LAST);

    always_comb begin
        last_value_d = accept ? value : last_value_q;
        cnt_d        = wrap ? '0 : cnt_q + 1'b1;
        idx_d        = idx_q;
        if (wrap) begin
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end
        // seg and an come from the same index in the same cycle
        seg_d = SEG_OFF;
        an_d  = 3'b111;
        case (idx_q)
            2'd0: begin seg_d = digit_seg[0]; an_d = 3'b110; end
            2'd1: begin seg_d = digit_seg[1]; an_d = 3'b101; end
            2'd2: begin seg_d = digit_seg[2]; an_d = 3'b011; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_value_q <= 8'h00;
            cnt_q        <= '0;
            idx_q        <= 2'd0;
            seg_q        <= SEG_OFF;
            an_q         <= 3'b111;
        end else begin
            last_value_q <= last_value_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign bcd  = conv_bcd;
    assign busy = conv_busy;

endmodule

// File: tb/tb_output_display.sv
// Randomized bench for output_display: two instances (slow scan with blanking,
// every-cycle scan without) checked each cycle against a decimal-arithmetic model.
module tb_output_display;

    localparam int DIV_A = 4;
    localparam int DIV_B = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  value;
    logic [6:0]  seg_a, seg_b;
    logic [2:0]  an_a, an_b;
    logic [11:0] bcd_a, bcd_b;
    logic        busy_a, busy_b;

    always #5 clk = ~clk;

    output_display #(.REFRESH_DIV(DIV_A), .BLANK_LEADING(1)) dut_a (
        .clk(clk), .rst(rst), .value(value),
        .seg(seg_a), .an(an_a), .bcd(bcd_a), .busy(busy_a)
    );

    output_display #(.REFRESH_DIV(DIV_B), .BLANK_LEADING(0)) dut_b (
        .clk(clk), .rst(rst), .value(value),
        .seg(seg_b), .an(an_b), .bcd(bcd_b), .busy(busy_b)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [2:0] an_tab [3]   = '{3'b110, 3'b101, 3'b011};

    // model state
    logic [7:0] m_last;
    int         m_left;
    int         m_shown;
    logic       m_busy;
    int         m_edge;
    logic [6:0] exp_seg_a, exp_seg_b;
    logic [2:0] exp_an_a, exp_an_b;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got=%h expected=%h (value=%0d)", tag, $time, got, exp, value);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h, t, u;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    function automatic logic [6:0] digit_seg(input int v, input int pos, input bit blank_en);
        int h, t, u;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
        if (pos == 0) return seg_tab[u];
        if (pos == 1) return (blank_en && h == 0 && t == 0) ? 7'h7F : seg_tab[t];
        return (blank_en && h == 0) ? 7'h7F : seg_tab[h];
    endfunction

    task automatic step();
        int idx_a, idx_b;
        @(posedge clk);
        if (rst) begin
            m_last = 8'h00; m_left = 0; m_shown = 0; m_busy = 1'b0; m_edge = 0;
            exp_seg_a = 7'h7F; exp_an_a = 3'b111;
            exp_seg_b = 7'h7F; exp_an_b = 3'b111;
        end else begin
            m_edge++;
            // display reflects the committed value as it stood before this edge
            idx_a = ((m_edge - 1) / DIV_A) % 3;
            idx_b = ((m_edge - 1) / DIV_B) % 3;
            exp_an_a  = an_tab[idx_a];
            exp_seg_a = digit_seg(m_shown, idx_a, 1'b1);
            exp_an_b  = an_tab[idx_b];
            exp_seg_b = digit_seg(m_shown, idx_b, 1'b0);
            if (m_left == 0) begin
                if (value != m_last) begin
                    m_last = value;
                    m_left = 9;
                    m_busy = 1'b1;
                end
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_shown = int'(m_last);
                    m_busy  = 1'b0;
                end
            end
        end
        #1;
        check_eq("bcd_a",  16'(bcd_a),  16'(to_bcd(m_shown)));
        check_eq("busy_a", 16'(busy_a), 16'(m_busy));
        check_eq("an_a",   16'(an_a),   16'(exp_an_a));
        check_eq("seg_a",  16'(seg_a),  16'(exp_seg_a));
        check_eq("bcd_b",  16'(bcd_b),  16'(to_bcd(m_shown)));
        check_eq("busy_b", 16'(busy_b), 16'(m_busy));
        check_eq("an_b",   16'(an_b),   16'(exp_an_b));
        check_eq("seg_b",  16'(seg_b),  16'(exp_seg_b));
    endtask

    int dir_vals [10] = '{1, 9, 10, 99, 100, 199, 209, 250, 255, 0};

    initial begin
        rst   = 1'b1;
        value = 8'd0;
        repeat (3) step();
        rst = 1'b0;
        repeat (30) step();

        value = 8'd255; repeat (30) step();
        value = 8'd7;   repeat (30) step();
        value = 8'd105; repeat (30) step();

        // change arrives mid-conversion and must be picked up afterwards
        value = 8'd42;  repeat (3) step();
        value = 8'd200; repeat (40) step();

        // reset during a shift with the value held
        value = 8'd255; repeat (5) step();
        rst = 1'b1; step();
        rst = 1'b0; repeat (30) step();

        foreach (dir_vals[i]) begin
            value = 8'(dir_vals[i]);
            repeat (15) step();
        end

        for (int i = 0; i < 150; i++) begin
            value = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) rst = 1'b1;
            repeat ($urandom_range(1, 14)) begin
                step();
                rst = 1'b0;
            end
        end
        repeat (15) step();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
